// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibits the bus, issues request-to-send,
// shifts out one byte with odd parity, and checks the device ACK.
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NO_ACK  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [7:0]      sh;
    logic            par;
    logic [IW-1:0]   icnt;
    logic [TW-1:0]   tcnt;
    logic [3:0]      bitcnt;
    logic [3:0]      bit_nxt;

    logic            sclk_p0;
    logic            sclk;
    logic            sdata_p0;
    logic            sdata;
    logic            prev_sclk;
    logic            fall;

    function automatic logic odd_parity(input logic [7:0] v);
        return ~^v;
    endfunction

    function automatic logic [IW-1:0] sat_inc_i(input logic [IW-1:0] v);
        return (v == {IW{1'b1}}) ? v : v + IW'(1);
    endfunction

    function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
        return (v == {TW{1'b1}}) ? v : v + TW'(1);
    endfunction

    // Pad synchronizers; prev_sclk adds one more stage for edge detection
    always_ff @(posedge clk) begin
        sclk_p0   <= ps2_clk;
        sclk      <= sclk_p0;
        sdata_p0  <= ps2_data;
        sdata     <= sdata_p0;
        prev_sclk <= sclk;
    end

    assign fall    = prev_sclk & ~sclk;
    assign bit_nxt = bitcnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            icnt        <= '0;
            tcnt        <= '0;
            bitcnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    // cmd_ready comes back one cycle after done/err
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (cmd_valid) begin
                        sh         <= cmd_data;
                        par        <= odd_parity(cmd_data);
                        icnt       <= '0;
                        ps2_clk_oe <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (icnt == INHIBIT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        icnt        <= '0;
                        tcnt        <= '0;
                        bitcnt      <= '0;
                        state       <= DATA;
                    end else begin
                        icnt <= sat_inc_i(icnt);
                    end
                end

                DATA, ACK, WAIT_IDLE: begin
                    // Timeout wins over any edge seen in the same cycle
                    if (tcnt == TIMEOUT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err         <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        tcnt <= sat_inc_t(tcnt);
                        if (state == DATA) begin
                            if (fall) begin
                                bitcnt <= bit_nxt;
                                if (bit_nxt <= 4'd8) begin
                                    ps2_data_oe <= ~sh[bitcnt[2:0]];
                                end else if (bit_nxt == 4'd9) begin
                                    ps2_data_oe <= ~par;
                                end else begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ACK;
                                end
                            end
                        end else if (state == ACK) begin
                            if (fall) begin
                                if (!sdata) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    err      <= 1'b1;
                                    err_code <= ERR_NO_ACK;
                                    state    <= IDLE;
                                end
                            end
                        end else begin
                            if (sclk && sdata) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device and a
// scoreboard of expected done/err outcomes checked by an independent monitor.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH = 8;
    localparam int TO  = 1000;
    localparam int H   = 20;   // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic        chk_bits;
        logic [10:0] bits;
        logic        chk_t;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [10:0] cap_bits;
    int          hi_run = 0;
    int          t_rel = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cond(input int sel, input logic val, input int limit, input string nm);
        int   n = 0;
        logic s;
        do begin
            @(negedge clk);
            case (sel)
                0: s = ps2_clk_oe;
                1: s = done;
                2: s = err;
                default: s = cmd_ready;
            endcase
            n++;
        end while (s !== val && n < limit);
        if (s !== val) chk(nm, {31'd0, s}, {31'd0, val});
    endtask

    // Behavioural device: waits for request-to-send, clocks nfall edges,
    // sampling data before the first fall and at each rising edge.
    task automatic dev_frame(input int nfall, input logic ack);
        wait_cond(0, 1'b1, 200, "rts_clk_low");
        wait_cond(0, 1'b0, 200, "rts_clk_release");
        repeat (H) tick();
        cap_bits[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            if (k <= nfall) begin
                dev_clk = 1'b0;
                repeat (H) tick();
                cap_bits[k] = ps2_data;
                dev_clk = 1'b1;
                repeat (H) tick();
            end
        end
        if (nfall >= 11) begin
            dev_data = ack ? 1'b0 : 1'b1;
            dev_clk  = 1'b0;
            repeat (H) tick();
            dev_clk = 1'b1;
            repeat (H) tick();
            dev_data = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        do begin
            tick();
            n++;
        end while (cmd_ready && n < 20);
        cmd_valid = 1'b0;
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic p, input logic ack);
        exp_t e;
        e.is_err   = ~ack;
        e.code     = ack ? 2'b00 : 2'b10;
        e.chk_bits = 1'b1;
        e.bits     = {1'b1, p, d, 1'b0};
        e.chk_t    = 1'b0;
        sb.push_back(e);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic p, input logic ack);
        push_frame(d, p, ack);
        send(d);
        dev_frame(11, ack);
        wait_cond(3, 1'b1, 200, "ready_return");
        chk("ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Monitor: inhibit width, release-to-pulse timing, scoreboard pops
    always @(negedge clk) begin
        if (reset) begin
            hi_run = 0;
        end else begin
            if (ps2_clk_oe) begin
                hi_run++;
            end else begin
                if (hi_run != 0) begin
                    chk("inhibit_len", hi_run, INH);
                    t_rel = 0;
                end else begin
                    t_rel++;
                end
                hi_run = 0;
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                    if (e.is_err) chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                    chk("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                    if (e.chk_bits) chk("frame_bits", {21'd0, cap_bits}, {21'd0, e.bits});
                    if (e.chk_t) chk("timeout_cycle", t_rel, TO);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) tick();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, done, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Nominal 0xED: bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1
        run_frame(8'hED, 1'b1, 1'b1);
        chk("nominal_err_code", {30'd0, err_code}, 32'd0);
        // Parity corners
        run_frame(8'h00, 1'b1, 1'b1);
        run_frame(8'h01, 1'b0, 1'b1);
        // No ACK
        run_frame(8'h55, 1'b1, 1'b0);
        chk("noack_code_held", {30'd0, err_code}, 32'd2);

        // Timeout: device never clocks
        e.is_err = 1'b1; e.code = 2'b01; e.chk_bits = 1'b0; e.bits = '0; e.chk_t = 1'b1;
        sb.push_back(e);
        send(8'hAA);
        wait_cond(2, 1'b1, 1200, "wait_timeout_err");
        wait_cond(3, 1'b1, 50, "ready_after_timeout");

        // Reset after edge 4 of 0xFF
        send(8'hFF);
        dev_frame(4, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_pulses", {30'd0, done, err}, 32'd0);
        repeat (5 * H) tick();
        run_frame(8'hF4, 1'b0, 1'b1);

        // Back-to-back with cmd_valid held
        push_frame(8'hFF, 1'b1, 1'b1);
        push_frame(8'hF4, 1'b0, 1'b1);
        send(8'hFF);
        cmd_valid = 1'b1;
        cmd_data  = 8'hF4;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        dev_frame(11, 1'b1);
        wait_cond(1, 1'b1, 200, "b2b_done1");
        @(negedge clk);
        chk("b2b_ready_rise", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_accept_next", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        dev_frame(11, 1'b1);
        wait_cond(3, 1'b1, 200, "b2b_ready_end");

        repeat (20) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
